// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage:
// PC mux selects, jump kinds and fetch FSM states.
package ifetch_unit_pkg;

    localparam logic [1:0] PC_MUX_SEL_NEWPC  = 2'b00;
    localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'b01;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_J    = 2'd1;
    localparam logic [1:0] JUMP_JR   = 2'd2;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC calculator: jr, then j/jal,
// then taken branch, else fall through to pc+4.
module ifetch_unit_npc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic [1:0]  PC_sel,
    input  logic [1:0]  IsJump,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic is_jr;
    logic is_j;
    logic is_br;

    // Priority is folded into mutually exclusive selects.
    assign is_jr = (IsJump == JUMP_JR);
    assign is_j  = (IsJump == JUMP_J);
    assign is_br = !is_jr && !is_j && branch_taken
                   && (PC_sel == PC_MUX_SEL_BRANCH);

    always_comb begin
        next_pc = pc_plus4;
        unique case (1'b1)
            is_jr:   next_pc = {jr_target[31:2], 2'b00};
            is_j:    next_pc = {pc_plus4[31:28], instr, 2'b00};
            is_br:   next_pc = pc_plus4 + br_offset(instr[15:0]);
            default: next_pc = pc_plus4;
        endcase
    end

    assign misaligned = is_jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, imem req/ready fetch,
// valid/ready hand-off to decode and next-PC commit on accept.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  PC_sel,
    input  logic [1:0]  IsJump,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic        addr_err
);

    fetch_state_e state;
    logic [31:0]  next_pc;
    logic         misaligned;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    ifetch_unit_npc u_npc (
        .pc_plus4     (pc_plus4),
        .instr        (instr[25:0]),
        .PC_sel       (PC_sel),
        .IsJump       (IsJump),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    // First cycle out of reset only raises the request.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_valid && instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                        if (misaligned)
                            addr_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the MIPS core: owns the PC register, fetches one instruction per step from instruction memory over a req/ready handshake, and presents it to the decoder (`ctrl`) and datapath with a valid/ready handshake. When the instruction is accepted, the block computes and commits the next PC from the `PC_sel` and `IsJump` decode outputs, the branch condition and the `jr` register target.

## Interface
- `RESET_PC`, default 32'h0000_3000, PC loaded on reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch byte address; equals `pc`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  memory response; sampled only while `imem_req`=1.
- `instr`  out  32  registered instruction word.
- `instr_valid`  out  1  `instr`, `pc` and `pc_plus4` are valid.
- `instr_ready`  in  1  downstream accepts the instruction this cycle.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4, mod 2^32; used as the jal link value.
- `PC_sel`  in  2  from `ctrl`: 2'b00 NEWPC, 2'b01 BRANCH.
- `IsJump`  in  2  from `ctrl`: 0 none, 1 j/jal, 2 jr.
- `branch_taken`  in  1  ALU branch condition (EQL/BNE result).
- `jr_target`  in  32  rs register value for jr.
- `addr_err`  out  1  sticky flag: a misaligned jr target was seen.

## Operation
- FSM states are FETCH and HOLD.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - When `imem_ready`=1: `instr` <= `imem_rdata`, then go to HOLD.
  - Otherwise stay in FETCH with `imem_addr` held stable.
- **HOLD:**
  - `instr_valid`=1 and `imem_req`=0.
  - On `instr_valid` & `instr_ready`: `pc` <= next_pc, then go to FETCH.
  - Otherwise stay in HOLD; `instr`, `pc` and `pc_plus4` are held.
- **next_pc** is combinational from inputs sampled in the accept cycle, in this priority order:
  - `IsJump`==2: {`jr_target`[31:2], 2'b00}. If `jr_target`[1:0]≠0, set `addr_err`.
  - `IsJump`==1: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - `PC_sel`==BRANCH and `branch_taken`: `pc_plus4` + (sign-extend(`instr`[15:0]) << 2), mod 2^32.
  - Otherwise: `pc_plus4`.
  - `IsJump`==3 is treated as 0.
- **Arithmetic:** all 32-bit and wraps silently (`pc` 32'hFFFF_FFFC gives `pc_plus4` 0). No delay slot.
- **Outputs during reset:** `pc`=`RESET_PC`, state=FETCH, `instr`=0, `instr_valid`=0, `imem_req`=0, `addr_err`=0.
- **Reset mid-operation** (in FETCH waiting on memory, or in HOLD) aborts immediately. Any `imem_ready` in the reset cycle is ignored. The first request after reset is to `RESET_PC`.
- Redirect inputs are ignored except in the accept cycle.

## Timing
- `imem_req` rises in the first cycle after `rst` falls.
- Zero-wait memory (`imem_ready`=1 in the request cycle): `instr_valid` rises 1 cycle after the request.
- With `instr_ready` tied high, one instruction is accepted every 2 cycles.
- Each memory wait cycle adds one cycle; each cycle `instr_ready` is held low adds one cycle.
- `instr_valid` never drops without an accept or a reset. `imem_req` and `instr_valid` are never both 1.
- The new PC appears on `imem_addr` in the cycle after the accept.

## Structure
- Shared defines file (`ctrl_encode_def.v`):
  - `PC_MUX_SEL_NEWPC`, `PC_MUX_SEL_BRANCH`.
  - New `JUMP_NONE`/`JUMP_J`/`JUMP_JR` encodings for `IsJump`.
  - Fetch state encodings.
- Sub-module `npc`: purely combinational next-PC calculator (inputs `pc_plus4`, `instr`, `PC_sel`, `IsJump`, `branch_taken`, `jr_target`; outputs `next_pc`, `misaligned`).
- `ifetch_unit` holds the FSM, the PC, instruction registers, and `addr_err`.

## Test plan
- **Reset and sequential fetch:** `rst` for 2 cycles, memory with zero wait, `instr_ready`=1 → `imem_addr` sequence 0x3000, 0x3004, 0x3008; `instr_valid` high every other cycle.
- **Memory wait and downstream backpressure:** memory inserts 3 wait cycles, `instr_ready` low for 2 cycles → `imem_addr` stable throughout the wait; `instr` and `pc` held; exactly one PC advance.
- **Branch:** beq at 0x3010, offset 16'hFFFC:
  - `branch_taken`=1 → next fetch 0x3004.
  - `branch_taken`=0 → next fetch 0x3014.
- **Jump:**
  - j with target field 26'h0000C10 at pc 0x3020 → next fetch 0x0000_3040.
  - jr with `jr_target`=0x3102 → next fetch 0x3100 and `addr_err`=1 (sticky until reset).
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFFC → `pc_plus4`=0 and second fetch at 0x0.
- **Reset mid-operation:** `rst` asserted in FETCH while `imem_ready`=1 → `instr` stays 0, `instr_valid` stays 0, and the next request is to `RESET_PC`.
